// File: rtl/bmult_26x26_bitheap_cmp.sv
// Bit-heap compressor for a 26x26 Baugh-Wooley multiplier: full-adder tree reduces the
// 52-column heap to two rows, a 53-bit CPA sums them, and the result is registered once.
module bmult_26x26_bitheap_cmp (
  input  logic         clk,
  input  logic         rst,
  input  logic [1:0]   in_col0,
  input  logic         in_col1,
  input  logic [2:0]   in_col2,
  input  logic [1:0]   in_col3,
  input  logic [3:0]   in_col4,
  input  logic [2:0]   in_col5,
  input  logic [4:0]   in_col6,
  input  logic [3:0]   in_col7,
  input  logic [5:0]   in_col8,
  input  logic [4:0]   in_col9,
  input  logic [6:0]   in_col10,
  input  logic [5:0]   in_col11,
  input  logic [7:0]   in_col12,
  input  logic [6:0]   in_col13,
  input  logic [8:0]   in_col14,
  input  logic [7:0]   in_col15,
  input  logic [9:0]   in_col16,
  input  logic [8:0]   in_col17,
  input  logic [10:0]  in_col18,
  input  logic [9:0]   in_col19,
  input  logic [11:0]  in_col20,
  input  logic [10:0]  in_col21,
  input  logic [12:0]  in_col22,
  input  logic [11:0]  in_col23,
  input  logic [13:0]  in_col24,
  input  logic [12:0]  in_col25,
  input  logic [13:0]  in_col26,
  input  logic [12:0]  in_col27,
  input  logic [11:0]  in_col28,
  input  logic [11:0]  in_col29,
  input  logic [10:0]  in_col30,
  input  logic [10:0]  in_col31,
  input  logic [9:0]   in_col32,
  input  logic [9:0]   in_col33,
  input  logic [8:0]   in_col34,
  input  logic [8:0]   in_col35,
  input  logic [7:0]   in_col36,
  input  logic [7:0]   in_col37,
  input  logic [6:0]   in_col38,
  input  logic [6:0]   in_col39,
  input  logic [5:0]   in_col40,
  input  logic [5:0]   in_col41,
  input  logic [4:0]   in_col42,
  input  logic [4:0]   in_col43,
  input  logic [3:0]   in_col44,
  input  logic [3:0]   in_col45,
  input  logic [2:0]   in_col46,
  input  logic [2:0]   in_col47,
  input  logic [1:0]   in_col48,
  input  logic [1:0]   in_col49,
  input  logic         in_col50,
  input  logic         in_col51,
  output logic [52:0]  comp_out
);

  localparam int unsigned N    = 26;
  localparam int unsigned NCOL = 2 * N;
  localparam int unsigned OW   = NCOL + 1;
  localparam int unsigned HMAX = 14;
  localparam int unsigned NST  = 6;

  // Uniform column height entering each stage: 14 -> 10 -> 7 -> 5 -> 4 -> 3 -> 2.
  function automatic int unsigned stage_h(input int unsigned s);
    case (s)
      0:       stage_h = 14;
      1:       stage_h = 10;
      2:       stage_h = 7;
      3:       stage_h = 5;
      4:       stage_h = 4;
      5:       stage_h = 3;
      default: stage_h = 2;
    endcase
  endfunction

  logic [HMAX-1:0] lvl [NST+1][OW];
  logic [OW-1:0]   row_a;
  logic [OW-1:0]   row_b;
  logic [OW-1:0]   comp_d;
  logic [OW-1:0]   comp_q;

  assign lvl[0][0]  = HMAX'(in_col0);
  assign lvl[0][1]  = HMAX'(in_col1);
  assign lvl[0][2]  = HMAX'(in_col2);
  assign lvl[0][3]  = HMAX'(in_col3);
  assign lvl[0][4]  = HMAX'(in_col4);
  assign lvl[0][5]  = HMAX'(in_col5);
  assign lvl[0][6]  = HMAX'(in_col6);
  assign lvl[0][7]  = HMAX'(in_col7);
  assign lvl[0][8]  = HMAX'(in_col8);
  assign lvl[0][9]  = HMAX'(in_col9);
  assign lvl[0][10] = HMAX'(in_col10);
  assign lvl[0][11] = HMAX'(in_col11);
  assign lvl[0][12] = HMAX'(in_col12);
  assign lvl[0][13] = HMAX'(in_col13);
  assign lvl[0][14] = HMAX'(in_col14);
  assign lvl[0][15] = HMAX'(in_col15);
  assign lvl[0][16] = HMAX'(in_col16);
  assign lvl[0][17] = HMAX'(in_col17);
  assign lvl[0][18] = HMAX'(in_col18);
  assign lvl[0][19] = HMAX'(in_col19);
  assign lvl[0][20] = HMAX'(in_col20);
  assign lvl[0][21] = HMAX'(in_col21);
  assign lvl[0][22] = HMAX'(in_col22);
  assign lvl[0][23] = HMAX'(in_col23);
  assign lvl[0][24] = HMAX'(in_col24);
  assign lvl[0][25] = HMAX'(in_col25);
  assign lvl[0][26] = HMAX'(in_col26);
  assign lvl[0][27] = HMAX'(in_col27);
  assign lvl[0][28] = HMAX'(in_col28);
  assign lvl[0][29] = HMAX'(in_col29);
  assign lvl[0][30] = HMAX'(in_col30);
  assign lvl[0][31] = HMAX'(in_col31);
  assign lvl[0][32] = HMAX'(in_col32);
  assign lvl[0][33] = HMAX'(in_col33);
  assign lvl[0][34] = HMAX'(in_col34);
  assign lvl[0][35] = HMAX'(in_col35);
  assign lvl[0][36] = HMAX'(in_col36);
  assign lvl[0][37] = HMAX'(in_col37);
  assign lvl[0][38] = HMAX'(in_col38);
  assign lvl[0][39] = HMAX'(in_col39);
  assign lvl[0][40] = HMAX'(in_col40);
  assign lvl[0][41] = HMAX'(in_col41);
  assign lvl[0][42] = HMAX'(in_col42);
  assign lvl[0][43] = HMAX'(in_col43);
  assign lvl[0][44] = HMAX'(in_col44);
  assign lvl[0][45] = HMAX'(in_col45);
  assign lvl[0][46] = HMAX'(in_col46);
  assign lvl[0][47] = HMAX'(in_col47);
  assign lvl[0][48] = HMAX'(in_col48);
  assign lvl[0][49] = HMAX'(in_col49);
  assign lvl[0][50] = HMAX'(in_col50);
  assign lvl[0][51] = HMAX'(in_col51);
  assign lvl[0][52] = '0;

  // Each stage: full adders on bit triples; sums stay, carries move one column up,
  // leftovers pass through. Padding bits are constant zero and fold away.
  for (genvar s = 0; s < NST; s++) begin : g_stage
    localparam int unsigned HI  = stage_h(s);
    localparam int unsigned NFA = HI / 3;
    localparam int unsigned SHR = 3 * NFA;
    localparam int unsigned SHL = 2 * NFA;

    logic [NFA-1:0] cy [OW];
    logic           unused_cy;

    // Carry out of the top column is the wrap beyond 2^53.
    assign unused_cy = ^cy[OW-1];

    for (genvar c = 0; c < OW; c++) begin : g_col
      logic [NFA-1:0] sm;
      logic [NFA-1:0] cin;

      for (genvar f = 0; f < NFA; f++) begin : g_fa
        assign {cy[c][f], sm[f]} = 2'(lvl[s][c][3*f]) + 2'(lvl[s][c][3*f+1])
                                 + 2'(lvl[s][c][3*f+2]);
      end

      if (c == 0) begin : g_c0
        assign cin = '0;
      end else begin : g_cn
        assign cin = cy[c-1];
      end

      assign lvl[s+1][c] = ((lvl[s][c] >> SHR) << SHL) | HMAX'({cin, sm});
    end
  end

  for (genvar c = 0; c < OW; c++) begin : g_rows
    logic unused_top;
    assign row_a[c]   = lvl[NST][c][0];
    assign row_b[c]   = lvl[NST][c][1];
    assign unused_top = ^lvl[NST][c][HMAX-1:2];
  end

  assign comp_d = row_a + row_b;

  always_ff @(posedge clk) begin
    if (rst) comp_q <= '0;
    else     comp_q <= comp_d;
  end

  assign comp_out = comp_q;

endmodule

// File: tb/tb_bmult_26x26_bitheap_cmp.sv
// Bench for the 26x26 bit-heap compressor: directed heaps plus random product-encoding
// heaps, compared with a column-popcount reference model.
module tb_bmult_26x26_bitheap_cmp;

  logic        clk = 1'b0;
  logic        rst;
  logic [13:0] heap [52];
  logic [52:0] comp_out;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  always #5 clk = ~clk;

  bmult_26x26_bitheap_cmp dut (
    .clk     (clk),
    .rst     (rst),
    .in_col0 (heap[0][1:0]),   .in_col1 (heap[1][0]),
    .in_col2 (heap[2][2:0]),   .in_col3 (heap[3][1:0]),
    .in_col4 (heap[4][3:0]),   .in_col5 (heap[5][2:0]),
    .in_col6 (heap[6][4:0]),   .in_col7 (heap[7][3:0]),
    .in_col8 (heap[8][5:0]),   .in_col9 (heap[9][4:0]),
    .in_col10(heap[10][6:0]),  .in_col11(heap[11][5:0]),
    .in_col12(heap[12][7:0]),  .in_col13(heap[13][6:0]),
    .in_col14(heap[14][8:0]),  .in_col15(heap[15][7:0]),
    .in_col16(heap[16][9:0]),  .in_col17(heap[17][8:0]),
    .in_col18(heap[18][10:0]), .in_col19(heap[19][9:0]),
    .in_col20(heap[20][11:0]), .in_col21(heap[21][10:0]),
    .in_col22(heap[22][12:0]), .in_col23(heap[23][11:0]),
    .in_col24(heap[24][13:0]), .in_col25(heap[25][12:0]),
    .in_col26(heap[26][13:0]), .in_col27(heap[27][12:0]),
    .in_col28(heap[28][11:0]), .in_col29(heap[29][11:0]),
    .in_col30(heap[30][10:0]), .in_col31(heap[31][10:0]),
    .in_col32(heap[32][9:0]),  .in_col33(heap[33][9:0]),
    .in_col34(heap[34][8:0]),  .in_col35(heap[35][8:0]),
    .in_col36(heap[36][7:0]),  .in_col37(heap[37][7:0]),
    .in_col38(heap[38][6:0]),  .in_col39(heap[39][6:0]),
    .in_col40(heap[40][5:0]),  .in_col41(heap[41][5:0]),
    .in_col42(heap[42][4:0]),  .in_col43(heap[43][4:0]),
    .in_col44(heap[44][3:0]),  .in_col45(heap[45][3:0]),
    .in_col46(heap[46][2:0]),  .in_col47(heap[47][2:0]),
    .in_col48(heap[48][1:0]),  .in_col49(heap[49][1:0]),
    .in_col50(heap[50][0]),    .in_col51(heap[51][0]),
    .comp_out(comp_out)
  );

  function automatic int hgt(input int c);
    if (c <= 25)       return (c % 2 == 0) ? c / 2 + 2 : (c + 1) / 2;
    else if (c == 26)  return 14;
    else if (c == 27)  return 13;
    else               return 26 - c / 2;
  endfunction

  function automatic logic [13:0] hmask(input int c);
    logic [14:0] m;
    m = (15'd1 << hgt(c)) - 15'd1;
    return m[13:0];
  endfunction

  // Reference: every bit of column c is worth 2^c; sum mod 2^53.
  function automatic logic [52:0] heap_sum();
    logic [63:0] s;
    s = '0;
    for (int c = 0; c < 52; c++)
      s += 64'($countones(heap[c] & hmask(c))) << c;
    return s[52:0];
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_heap();
    for (int c = 0; c < 52; c++) heap[c] = '0;
  endtask

  task automatic tick_check(input string tag, input logic [52:0] exp);
    @(posedge clk);
    #1;
    check(tag, 64'(comp_out), 64'(exp));
  endtask

  // Random heap whose weighted sum is congruent to t mod 2^52: random filler in the
  // upper bits of each column, bit 0 of every column chosen to make up the difference.
  task automatic product_heap(input logic [51:0] t, input int mode);
    logic [51:0] r;
    logic [51:0] d;
    logic [13:0] w;
    r = '0;
    for (int c = 0; c < 52; c++) begin
      w = 14'($urandom);
      if (mode == 1)      w = w & 14'($urandom);
      else if (mode == 2) w = w | 14'($urandom);
      else if (mode == 3) w = 14'h3FFF;
      heap[c] = w & hmask(c) & ~14'd1;
      r += 52'($countones(heap[c])) << c;
    end
    d = t - r;
    for (int c = 0; c < 52; c++) heap[c][0] = d[c];
  endtask

  initial begin
    logic signed [25:0] a;
    logic signed [25:0] b;
    longint             p;
    logic [51:0]        t;
    logic [52:0]        exp_s;

    rst = 1'b1;
    for (int c = 0; c < 52; c++) heap[c] = 14'($urandom) & hmask(c);
    tick_check("reset0", 53'd0);
    tick_check("reset1", 53'd0);

    rst = 1'b0;
    clear_heap();
    tick_check("zero_heap", 53'd0);

    heap[0] = 14'b11;
    tick_check("col0_11", 53'd2);
    heap[0] = 14'b01;
    tick_check("col0_01", 53'd1);

    clear_heap();
    heap[26] = 14'h3FFF;
    tick_check("col26_full", 53'h0003_8000_000);
    clear_heap();
    heap[51] = 14'd1;
    tick_check("col51", 53'h8_0000_0000_0000);

    clear_heap();
    heap[1] = 14'd1;
    tick_check("b2b_0", 53'd2);
    clear_heap();
    heap[2] = 14'b111;
    tick_check("b2b_1", 53'd12);
    clear_heap();
    tick_check("b2b_2", 53'd0);

    // Top four columns full: carries must ripple into bit 52.
    heap[48] = 14'h3; heap[49] = 14'h3; heap[50] = 14'h1; heap[51] = 14'h1;
    tick_check("top_carry", 53'h12_0000_0000_0000);

    for (int i = 0; i < 20000; i++) begin
      case (i)
        0:       begin a = -26'sd33554432; b = -26'sd33554432; end
        1:       begin a = 26'sd33554431;  b = -26'sd33554432; end
        2:       begin a = -26'sd1;        b = -26'sd1;        end
        3:       begin a = 26'sd0;         b = 26'($urandom);  end
        default: begin a = 26'($urandom);  b = 26'($urandom);  end
      endcase
      p = longint'(a) * longint'(b);
      t = p[51:0];
      product_heap(t, i % 4);
      exp_s = heap_sum();
      rst = (i == 7000 || i == 13001);
      @(posedge clk);
      #1;
      if (rst) begin
        check("mid_rst", 64'(comp_out), 64'd0);
      end else begin
        check("rand_sum", 64'(comp_out), 64'(exp_s));
        check("rand_prod", 64'(comp_out[51:0]), 64'(t));
      end
    end
    rst = 1'b0;

    for (int c = 0; c < 52; c++) heap[c] = hmask(c);
    exp_s = heap_sum();
    @(posedge clk);
    #1;
    check("all_ones", 64'(comp_out), 64'(exp_s));
    check("all_ones_b52", 64'(comp_out[52]), 64'(exp_s[52]));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
